// File: rtl/scene_sequencer_pkg.sv
// Shared definitions for the video pipeline: sequencer state encoding and
// default raster geometry used by the timing, graphics and sequencer blocks.
package scene_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FADE_IN  = 2'd0,
        ST_RUN      = 2'd1,
        ST_PAUSE    = 2'd2,
        ST_FADE_OUT = 2'd3
    } state_t;

    localparam int unsigned H_ACTIVE_DEFAULT = 640;
    localparam int unsigned V_ACTIVE_DEFAULT = 480;

    // Auto-advance order: 0 -> 1 -> 2 -> 3 -> 0.
    function automatic logic [1:0] next_scene(input logic [1:0] s);
        return s + 2'd1;
    endfunction

endpackage

// File: rtl/scene_sequencer_cfg_sync.sv
// Two-flop synchronizer for asynchronous level controls plus one strobe input
// whose rising edge is detected after synchronization.
module cfg_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] lvl_async,
    input  logic             strobe_async,
    output logic [WIDTH-1:0] lvl_sync,
    output logic             strobe_rise
);

    logic [WIDTH:0] meta_q, meta_d;
    logic [WIDTH:0] sync_q, sync_d;
    logic           strobe_prev_q, strobe_prev_d;

    always_comb begin
        meta_d        = {strobe_async, lvl_async};
        sync_d        = meta_q;
        strobe_prev_d = sync_q[WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q        <= '0;
            sync_q        <= '0;
            strobe_prev_q <= 1'b0;
        end else begin
            meta_q        <= meta_d;
            sync_q        <= sync_d;
            strobe_prev_q <= strobe_prev_d;
        end
    end

    assign lvl_sync    = sync_q[WIDTH-1:0];
    assign strobe_rise = sync_q[WIDTH] & ~strobe_prev_q;

endmodule

// File: rtl/scene_sequencer.sv
// Scene sequencer: fades scenes in and out, scrolls the active scene once per
// frame and handles asynchronous pause / scene-load requests.
module scene_sequencer
    import scene_sequencer_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = H_ACTIVE_DEFAULT,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEFAULT,
    parameter int unsigned SCENE_FRAMES = 240,
    parameter int unsigned FADE_FRAMES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       cfg_pause,
    input  logic       cfg_load,
    input  logic [1:0] cfg_scene,
    input  logic [1:0] cfg_speed,
    output logic       frame_tick,
    output logic [1:0] scene,
    output logic [9:0] scroll_x,
    output logic [9:0] scroll_y,
    output logic [1:0] fade_level,
    output logic       audio_en
);

    localparam int unsigned FC_W = $clog2(SCENE_FRAMES + 1);
    localparam int unsigned FD_W = $clog2(FADE_FRAMES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(SCENE_FRAMES - 1);
    localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);
    localparam logic [FD_W-1:0] FD_LAST = FD_W'(FADE_FRAMES - 1);
    localparam logic [FD_W-1:0] FD_ONE  = FD_W'(1);
    localparam logic [9:0]      H_LIM   = 10'(H_ACTIVE);
    localparam logic [9:0]      V_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [9:0]      V_TICK  = 10'(V_ACTIVE);

    state_t            state_q, state_d;
    logic [1:0]        fade_q, fade_d;
    logic [1:0]        scene_q, scene_d;
    logic [1:0]        target_q, target_d;
    logic [1:0]        y_div_q, y_div_d;
    logic              pending_q, pending_d;
    logic              frame_tick_q, frame_tick_d;
    logic              audio_en_q, audio_en_d;
    logic [9:0]        scroll_x_q, scroll_x_d;
    logic [9:0]        scroll_y_q, scroll_y_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [FD_W-1:0]   fade_cnt_q, fade_cnt_d;
    logic [9:0]        sum_x;

    logic [2:0]        cfg_lvl_s;
    logic              load_rise;
    logic              pause_s;
    logic [1:0]        scene_s;

    cfg_sync #(
        .WIDTH(3)
    ) u_cfg_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .lvl_async   ({cfg_pause, cfg_scene}),
        .strobe_async(cfg_load),
        .lvl_sync    (cfg_lvl_s),
        .strobe_rise (load_rise)
    );

    assign pause_s = cfg_lvl_s[2];
    assign scene_s = cfg_lvl_s[1:0];

    always_comb begin
        state_d      = state_q;
        fade_d       = fade_q;
        scene_d      = scene_q;
        target_d     = target_q;
        y_div_d      = y_div_q;
        pending_d    = pending_q;
        scroll_x_d   = scroll_x_q;
        scroll_y_d   = scroll_y_q;
        frame_cnt_d  = frame_cnt_q;
        fade_cnt_d   = fade_cnt_q;
        frame_tick_d = (x == 10'd0) && (y == V_TICK);
        sum_x        = scroll_x_q + {8'd0, cfg_speed};

        // All visible state moves only in the cycle after frame_tick (vblank).
        if (frame_tick_q) begin
            unique case (state_q)
                ST_FADE_IN: begin
                    if (fade_cnt_q == FD_LAST) begin
                        fade_cnt_d = '0;
                        fade_d     = fade_q + 2'd1;
                        if (fade_q == 2'd2) state_d = ST_RUN;
                    end else begin
                        fade_cnt_d = fade_cnt_q + FD_ONE;
                    end
                end
                ST_RUN: begin
                    scroll_x_d  = (sum_x >= H_LIM) ? (sum_x - H_LIM) : sum_x;
                    if ((cfg_speed != 2'd0) && (y_div_q == 2'd3))
                        scroll_y_d = (scroll_y_q == V_LAST) ? '0 : scroll_y_q + 10'd1;
                    y_div_d     = y_div_q + 2'd1;
                    frame_cnt_d = frame_cnt_q + FC_ONE;
                    // A pending load beats both auto-advance and pause.
                    if (pending_q) begin
                        state_d    = ST_FADE_OUT;
                        pending_d  = 1'b0;
                        fade_cnt_d = '0;
                    end else if (frame_cnt_q == FC_LAST) begin
                        state_d    = ST_FADE_OUT;
                        target_d   = next_scene(scene_q);
                        fade_cnt_d = '0;
                    end else if (pause_s) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (pending_q) begin
                        state_d    = ST_FADE_OUT;
                        pending_d  = 1'b0;
                        fade_cnt_d = '0;
                    end else if (!pause_s) begin
                        state_d = ST_RUN;
                    end
                end
                ST_FADE_OUT: begin
                    if (fade_cnt_q == FD_LAST) begin
                        fade_cnt_d = '0;
                        fade_d     = fade_q - 2'd1;
                        if (fade_q == 2'd1) begin
                            scene_d     = target_q;
                            scroll_x_d  = '0;
                            scroll_y_d  = '0;
                            frame_cnt_d = '0;
                            y_div_d     = '0;
                            state_d     = ST_FADE_IN;
                        end
                    end else begin
                        fade_cnt_d = fade_cnt_q + FD_ONE;
                    end
                end
            endcase
        end

        // During a fade a load only retargets; it never queues another fade.
        if (load_rise) begin
            target_d = scene_s;
            if ((state_q == ST_RUN) || (state_q == ST_PAUSE)) pending_d = 1'b1;
        end

        audio_en_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FADE_IN;
            fade_q       <= '0;
            scene_q      <= '0;
            target_q     <= '0;
            y_div_q      <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            audio_en_q   <= 1'b0;
            scroll_x_q   <= '0;
            scroll_y_q   <= '0;
            frame_cnt_q  <= '0;
            fade_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            fade_q       <= fade_d;
            scene_q      <= scene_d;
            target_q     <= target_d;
            y_div_q      <= y_div_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
            audio_en_q   <= audio_en_d;
            scroll_x_q   <= scroll_x_d;
            scroll_y_q   <= scroll_y_d;
            frame_cnt_q  <= frame_cnt_d;
            fade_cnt_q   <= fade_cnt_d;
        end
    end

    assign frame_tick = frame_tick_q;
    assign scene      = scene_q;
    assign scroll_x   = scroll_x_q;
    assign scroll_y   = scroll_y_q;
    assign fade_level = fade_q;
    assign audio_en   = audio_en_q;

endmodule
